// File: rtl/mult_sequencer.sv
// mult_sequencer: 8-bit signed shift-add multiplier sequencer.
// Produces the 16-bit two's-complement product {A,B} of a latched multiplicand
// S and multiplier B in 8 add/shift iterations. The last iteration subtracts
// S because B's original bit 7 carries negative weight.
module mult_sequencer (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       ClearA_LoadB,
  input  logic [7:0] Sw,
  output logic [7:0] Aval,
  output logic [7:0] Bval,
  output logic       Xval,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_x;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [7:0]  r_s;
  logic [2:0]  r_k;
  logic        r_busy;
  logic        r_done;

  logic        w_sub;
  logic        w_last;
  logic [8:0]  w_opnd;
  logic [8:0]  w_sum;

  assign w_last = (r_k == 3'd7);
  assign w_sub  = w_last;

  // 9-bit sign-extended add, or subtract (invert + carry-in) on the last step
  always_comb begin
    w_opnd = {r_s[7], r_s};
    if (w_sub) begin
      w_opnd = ~w_opnd;
    end
    w_sum = {r_a[7], r_a} + w_opnd + {8'd0, w_sub};
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; ClearA_LoadB outranks Run in IDLE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!ClearA_LoadB && Run) begin
          w_next_state = ST_ADD;
        end
      end
      ST_ADD: begin
        w_next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_last) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_ADD;
        end
      end
      ST_DONE: begin
        if (!Run) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Datapath registers X, A, B, latched multiplicand S and iteration counter k
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_x <= 1'b0;
      r_a <= '0;
      r_b <= '0;
      r_s <= '0;
      r_k <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ClearA_LoadB) begin
            r_x <= 1'b0;
            r_a <= '0;
            r_b <= Sw;
          end else if (Run) begin
            r_s <= Sw;
            r_x <= 1'b0;
            r_a <= '0;
            r_k <= '0;
          end
        end
        ST_ADD: begin
          if (r_b[0]) begin
            r_x <= w_sum[8];
            r_a <= w_sum[7:0];
          end
        end
        ST_SHIFT: begin
          r_a <= {r_x, r_a[7:1]};
          r_b <= {r_a[0], r_b[7:1]};
          if (!w_last) begin
            r_k <= r_k + 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status flags registered from the next state so they align with r_state
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next_state == ST_ADD) || (w_next_state == ST_SHIFT);
      r_done <= (w_next_state == ST_DONE);
    end
  end

  assign Aval = r_a;
  assign Bval = r_b;
  assign Xval = r_x;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed self-checking bench for mult_sequencer.
module tb_mult_sequencer;

  logic       Clk;
  logic       Reset;
  logic       Run;
  logic       ClearA_LoadB;
  logic [7:0] Sw;
  logic [7:0] Aval;
  logic [7:0] Bval;
  logic       Xval;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt;

  mult_sequencer dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .Sw           (Sw),
    .Aval         (Aval),
    .Bval         (Bval),
    .Xval         (Xval),
    .busy         (busy),
    .done         (done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_b(input logic [7:0] v, input string tag);
    Sw = v;
    ClearA_LoadB = 1'b1;
    step();
    ClearA_LoadB = 1'b0;
    check({tag, "_b"}, {24'd0, Bval}, {24'd0, v});
    check({tag, "_a"}, {24'd0, Aval}, 32'd0);
  endtask

  task automatic run_mult(input logic [7:0] s, input logic [15:0] exp_ab,
                          input logic exp_x, input logic chk_a0, input string tag);
    int c;
    Sw  = s;
    Run = 1'b1;
    step();
    Run = 1'b0;
    c = 0;
    while (busy && c < 40) begin
      if (chk_a0) check({tag, "_a_hold"}, {24'd0, Aval}, 32'd0);
      c++;
      step();
    end
    check({tag, "_busy_cycles"}, c, 32'd16);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_prod"}, {16'd0, Aval, Bval}, {16'd0, exp_ab});
    check({tag, "_x"}, {31'd0, Xval}, {31'd0, exp_x});
    step();
    check({tag, "_done_fall"}, {31'd0, done}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    Reset = 1'b1;
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    Sw = 8'h00;
    step();
    step();
    Reset = 1'b0;
    check("rst_a", {24'd0, Aval}, 32'd0);
    check("rst_b", {24'd0, Bval}, 32'd0);
    check("rst_x", {31'd0, Xval}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);

    // 7 x -3 = -21
    load_b(8'h07, "ld07");
    run_mult(8'hFD, 16'hFFEB, 1'b1, 1'b0, "m7xm3");
    // -8 x -8 = 64
    load_b(8'hF8, "ldF8");
    run_mult(8'hF8, 16'h0040, 1'b0, 1'b0, "m8x8");
    // -128 x -128 = 16384
    load_b(8'h80, "ld80");
    run_mult(8'h80, 16'h4000, 1'b0, 1'b0, "m128x128");
    // 127 x -128 = -16256
    load_b(8'h7F, "ld7F");
    run_mult(8'h80, 16'hC080, 1'b1, 1'b0, "m127x128");

    // ClearA_LoadB wins over Run in IDLE; A was 0xC0 beforehand
    Sw = 8'h33;
    Run = 1'b1;
    ClearA_LoadB = 1'b1;
    step();
    ClearA_LoadB = 1'b0;
    check("prio_b", {24'd0, Bval}, 32'h33);
    check("prio_a", {24'd0, Aval}, 32'd0);
    check("prio_busy", {31'd0, busy}, 32'd0);
    // 0x33 x 2 = 0x66
    run_mult(8'h02, 16'h0066, 1'b0, 1'b0, "m33x2");

    // Zero multiplier / zero multiplicand
    load_b(8'h00, "ld00");
    run_mult(8'h5A, 16'h0000, 1'b0, 1'b1, "m0x5A");
    load_b(8'h05, "ld05");
    run_mult(8'h00, 16'h0000, 1'b0, 1'b0, "m5x0");

    // Reset in the middle of a multiply
    load_b(8'h07, "ld07b");
    Sw = 8'hFD;
    Run = 1'b1;
    step();
    Run = 1'b0;
    for (int i = 0; i < 5; i++) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("mid_rst_a", {24'd0, Aval}, 32'd0);
    check("mid_rst_b", {24'd0, Bval}, 32'd0);
    check("mid_rst_x", {31'd0, Xval}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    load_b(8'h03, "ld03");
    run_mult(8'h05, 16'h000F, 1'b0, 1'b0, "m3x5");

    // Run held 40 cycles, Sw toggled and ClearA_LoadB pulsed mid-operation: -5 x 6 = -30
    load_b(8'hFB, "ldFB");
    Sw = 8'h06;
    Run = 1'b1;
    step();
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      Sw = cnt[7:0] ^ 8'hA5;
      ClearA_LoadB = (cnt == 5);
      step();
    end
    ClearA_LoadB = 1'b0;
    check("hold_busy_cycles", cnt, 32'd16);
    check("hold_prod", {16'd0, Aval, Bval}, 32'h0000FFE2);
    check("hold_x", {31'd0, Xval}, 32'd1);
    for (int i = 0; i < 40 - cnt - 1; i++) step();
    check("hold_done_stays", {31'd0, done}, 32'd1);
    check("hold_no_restart", {31'd0, busy}, 32'd0);
    check("hold_prod_kept", {16'd0, Aval, Bval}, 32'h0000FFE2);
    Run = 1'b0;
    step();
    check("hold_done_fall", {31'd0, done}, 32'd0);

    // Back-to-back without reload: B still 0xE2 (-30); -30 x 2 = -60
    run_mult(8'h02, 16'hFFC4, 1'b1, 1'b0, "b2b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
